ps2_direction_rx: RTL

PS/2 keyboard receiver and scan-code decoder that turns keystrokes on the `PS2C`/`PS2D` pins into snake direction commands. It sits in `top` beside the button logic and drives the same `move` encoding (right=0, up=1, left=2, down=3) plus a one-cycle enable pulse into `snake_game`. It also exposes raw received bytes and a frame-error pulse for debug LEDs.

---
 rtl/ps2_direction_rx.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/ps2_direction_rx.sv
// PS/2 keyboard receiver with scan-code to direction decoding.
// Conditions the asynchronous PS/2 pins, frames 11-bit PS/2 words and
// turns WASD / extended arrow make-codes into the snake move encoding
// (right=0, up=1, left=2, down=3).
module ps2_direction_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50_000
) (
    input  logic       mclk,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       ps2d,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_error,
    output logic [1:0] move,
    output logic       move_valid
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    logic                  c_meta, c_sync;
    logic                  d_meta, d_sync;
    logic [FILTER_LEN-1:0] filt;
    logic [FILTER_LEN-1:0] filt_next;
    logic                  fclk;
    logic                  sample;
    logic                  timeout;
    logic [1:0]            state;
    logic [2:0]            bit_cnt;
    logic [7:0]            shreg;
    logic                  par_bit;
    logic [TW-1:0]         tcnt;
    logic                  ext, brk;
    logic                  map_hit;
    logic [1:0]            map_dir;

    // The filter sees this cycle's synchronized sample so that fclk changes
    // exactly FILTER_LEN cycles after the synchronized level settles.
    assign filt_next = {filt[FILTER_LEN-2:0], c_sync};
    assign sample    = fclk && (filt_next == '0);
    assign timeout   = (state != ST_IDLE) && (tcnt == TW'(TIMEOUT_CYCLES - 1));

    // Two-stage synchronizers for both pins; idle level of the bus is high.
    // NOTE: every clocked block uses non-blocking (<=) assignments so that all
    // registers update together from the values present before the edge.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            c_meta <= 1'b1;
            c_sync <= 1'b1;
            d_meta <= 1'b1;
            d_sync <= 1'b1;
        end else begin
            c_meta <= ps2c;
            c_sync <= c_meta;
            d_meta <= ps2d;
            d_sync <= d_meta;
        end
    end

    // Glitch filter: fclk only follows ps2c after FILTER_LEN equal samples.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            filt <= '1;
            fclk <= 1'b1;
        end else begin
            filt <= filt_next;
            if (filt_next == '1)
                fclk <= 1'b1;
            else if (filt_next == '0)
                fclk <= 1'b0;
        end
    end

    // Idle-time counter since the last sample event while inside a frame.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset)
            tcnt <= '0;
        else if (state == ST_IDLE || sample || timeout)
            tcnt <= '0;
        else
            tcnt <= tcnt + TW'(1);
    end

    // Frame FSM: start, 8 data bits LSB first, odd parity, stop.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            bit_cnt     <= 3'd0;
            shreg       <= 8'h00;
            par_bit     <= 1'b0;
            scan_code   <= 8'h00;
            scan_valid  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            scan_valid  <= 1'b0;
            frame_error <= 1'b0;
            if (timeout) begin
                // A stalled frame is dropped; a coincident sample is ignored.
                state       <= ST_IDLE;
                frame_error <= 1'b1;
            end else if (sample) begin
                case (state)
                    ST_IDLE: begin
                        if (!d_sync) begin
                            state   <= ST_DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    ST_DATA: begin
                        shreg   <= {d_sync, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        par_bit <= d_sync;
                        state   <= ST_STOP;
                    end
                    default: begin
                        if (d_sync && (^{shreg, par_bit})) begin
                            scan_code  <= shreg;
                            scan_valid <= 1'b1;
                        end else begin
                            frame_error <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Direction lookup for the most recent byte under the current prefix.
    // NOTE: outputs of a combinational block get a default first, so no path
    // leaves them unassigned and no latch is inferred.
    always_comb begin
        map_hit = 1'b0;
        map_dir = 2'd0;
        if (ext) begin
            case (scan_code)
                8'h74: begin map_hit = 1'b1; map_dir = 2'd0; end
                8'h75: begin map_hit = 1'b1; map_dir = 2'd1; end
                8'h6B: begin map_hit = 1'b1; map_dir = 2'd2; end
                8'h72: begin map_hit = 1'b1; map_dir = 2'd3; end
                default: ;
            endcase
        end else begin
            case (scan_code)
                8'h23: begin map_hit = 1'b1; map_dir = 2'd0; end
                8'h1D: begin map_hit = 1'b1; map_dir = 2'd1; end
                8'h1C: begin map_hit = 1'b1; map_dir = 2'd2; end
                8'h1B: begin map_hit = 1'b1; map_dir = 2'd3; end
                default: ;
            endcase
        end
    end

    // Prefix tracking (E0 extended, F0 break) and direction output.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            ext        <= 1'b0;
            brk        <= 1'b0;
            move       <= 2'd0;
            move_valid <= 1'b0;
        end else begin
            move_valid <= 1'b0;
            if (frame_error) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (scan_valid) begin
                if (scan_code == 8'hE0) begin
                    ext <= 1'b1;
                end else if (scan_code == 8'hF0) begin
                    brk <= 1'b1;
                end else begin
                    if (!brk && map_hit) begin
                        move       <= map_dir;
                        move_valid <= 1'b1;
                    end
                    ext <= 1'b0;
                    brk <= 1'b0;
                end
            end
        end
    end

endmodule
